// File: rtl/muldiv_issue_ctrl_if.sv
// Handshake/bus bundle between decode, the RV32M unit and writeback for
// muldiv_issue_ctrl. The slave modport is the controller's view; the master
// modport is the surrounding pipeline (decode, RV32M, writeback).
interface muldiv_issue_ctrl_if #(
  parameter int XLEN = 32
);
  // decode -> controller
  logic            IN_VALID;
  logic            IN_READY;
  logic [2:0]      IN_FUNCT3;
  logic [XLEN-1:0] IN_RS1;
  logic [XLEN-1:0] IN_RS2;
  logic [4:0]      IN_RD;
  // controller <-> RV32M
  logic            M_START;
  logic [2:0]      M_CNT;
  logic [XLEN-1:0] M_RS1;
  logic [XLEN-1:0] M_RS2;
  logic            M_STALL;
  logic [XLEN-1:0] M_OUT;
  logic            M_READY;
  // controller -> writeback
  logic            WB_VALID;
  logic            WB_READY;
  logic [4:0]      WB_RD;
  logic [XLEN-1:0] WB_DATA;
  logic            WB_ERR;

  modport slave (
    input  IN_VALID, IN_FUNCT3, IN_RS1, IN_RS2, IN_RD,
    input  M_OUT, M_READY, WB_READY,
    output IN_READY, M_START, M_CNT, M_RS1, M_RS2, M_STALL,
    output WB_VALID, WB_RD, WB_DATA, WB_ERR
  );

  modport master (
    output IN_VALID, IN_FUNCT3, IN_RS1, IN_RS2, IN_RD,
    output M_OUT, M_READY, WB_READY,
    input  IN_READY, M_START, M_CNT, M_RS1, M_RS2, M_STALL,
    input  WB_VALID, WB_RD, WB_DATA, WB_ERR
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// Issue/sequencing controller in front of the RV32M multiply/divide unit.
// Accepts one M op from decode, holds operands on the unit until READY (or a
// timeout), then presents the result to writeback.
// Optional build macro MULDIV_DIV0_BYPASS_EN: divide/remainder by zero is
// answered locally without starting the unit.
//
// state  | meaning
// IDLE   | no op in flight, ready for decode
// ISSUE  | first START cycle; unit READY may still be stale, ignored
// WAIT   | unit running; timeout counter advancing
// HOLD   | result (or timeout error) held for writeback
module muldiv_issue_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FLUSH,
  output logic               PIPE_STALL,
  muldiv_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Timeout fires when the incremented count hits TIMEOUT_CYCLES-1, giving
  // TIMEOUT_CYCLES-1 WAIT cycles before the error result is posted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_err_q, wb_err_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;

  logic in_ready;
  logic m_start;
  logic pipe_stall;
  logic accept;

  // Next-state, datapath capture and handshake outputs
  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wb_valid_d = wb_valid_q;
    wb_err_d   = wb_err_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    in_ready   = 1'b0;
    m_start    = 1'b0;
    pipe_stall = 1'b0;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_ISSUE: begin
        m_start    = 1'b1;
        pipe_stall = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        m_start    = 1'b1;
        pipe_stall = 1'b1;
        cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (bus.M_READY) begin
          wb_data_d  = bus.M_OUT;
          wb_rd_d    = rd_q;
          wb_err_d   = 1'b0;
          wb_valid_d = 1'b1;
          state_d    = S_HOLD;
        end else if (cnt_d == CNT_LAST) begin
          wb_data_d  = '0;
          wb_rd_d    = rd_q;
          wb_err_d   = 1'b1;
          wb_valid_d = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        in_ready   = bus.WB_READY;
        pipe_stall = ~bus.WB_READY;
        if (bus.WB_READY) begin
          wb_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush cycle never takes a new op.
    if (FLUSH) begin
      in_ready = 1'b0;
    end

    accept = bus.IN_VALID & in_ready;
    if (accept) begin
      funct3_d = bus.IN_FUNCT3;
      rs1_d    = bus.IN_RS1;
      rs2_d    = bus.IN_RS2;
      rd_d     = bus.IN_RD;
      state_d  = S_ISSUE;
`ifdef MULDIV_DIV0_BYPASS_EN
      // funct3[2] selects the divide group; funct3[1] picks rem over div.
      if (bus.IN_FUNCT3[2] && (bus.IN_RS2 == '0)) begin
        wb_data_d  = bus.IN_FUNCT3[1] ? bus.IN_RS1 : '1;
        wb_rd_d    = bus.IN_RD;
        wb_err_d   = 1'b0;
        wb_valid_d = 1'b1;
        state_d    = S_HOLD;
      end
`else
`endif
    end

    // Flush drops the op but keeps the latched operands on the unit inputs.
    if (FLUSH) begin
      state_d    = S_IDLE;
      wb_valid_d = 1'b0;
      wb_err_d   = 1'b0;
    end
  end

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      funct3_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_err_q   <= wb_err_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign bus.IN_READY = in_ready;
  assign bus.M_START  = m_start;
  assign bus.M_STALL  = ~m_start;
  assign bus.M_CNT    = funct3_q;
  assign bus.M_RS1    = rs1_q;
  assign bus.M_RS2    = rs2_q;
  assign bus.WB_VALID = wb_valid_q;
  assign bus.WB_ERR   = wb_err_q;
  assign bus.WB_DATA  = wb_data_q;
  assign bus.WB_RD    = wb_rd_q;
  assign PIPE_STALL   = pipe_stall;

endmodule
